// File: rtl/i2s_sample_tx.sv
// I2S transmitter: one-pair holding buffer with valid/ready, BCLK/LRCLK generation
// from the system clock, and silence substitution when no pair is waiting at frame start.
module i2s_sample_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] leftSampleIn,
  input  logic [15:0] rightSampleIn,
  input  logic        sampleValid,
  output logic        sampleReady,
  input  logic        mute,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic             hold_full_q, hold_full_d;
  logic [31:0]      hold_data_q, hold_data_d;

  logic             div_wrap;
  logic             fall_strobe;
  logic             frame_start;
  logic             accept;
  logic [31:0]      frame_word;

  always_comb begin
    div_wrap    = (div_cnt_q == DIV_LAST);
    fall_strobe = div_wrap && bclk_q;
    frame_start = fall_strobe && (bit_cnt_q == 5'd31);
    accept      = sampleValid && !hold_full_q;
    frame_word  = (hold_full_q && !mute) ? hold_data_q : 32'h0;
  end

  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
  end

  // Everything the codec sees moves on the falling BCLK strobe, half a BCLK
  // period ahead of the rising edge where the codec samples sdata.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    underrun_d = frame_start && !hold_full_q;
    if (fall_strobe) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      sdata_d   = shift_q[31];
      if (frame_start) begin
        shift_d = frame_word;
        lrclk_d = 1'b0;
      end else begin
        shift_d = {shift_q[30:0], 1'b0};
        if (bit_cnt_q == 5'd15) begin
          lrclk_d = 1'b1;
        end
      end
    end
  end

  // Frame start drains the buffer before a same-cycle accept refills it, so a
  // pair arriving exactly at an empty frame start waits for the next frame.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (frame_start) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = {leftSampleIn, rightSampleIn};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      bit_cnt_q   <= 5'd31;
      shift_q     <= 32'h0;
      hold_full_q <= 1'b0;
      hold_data_q <= 32'h0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign sampleReady = ~hold_full_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: timing table after reset plus a frame scoreboard that
// decodes sdata at BCLK rises and compares each frame with the pair it should carry.
module tb_i2s_sample_tx;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 64 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_in = 16'h0;
  logic [15:0] right_in = 16'h0;
  logic        valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  i2s_sample_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .leftSampleIn (left_in),
    .rightSampleIn(right_in),
    .sampleValid  (valid),
    .sampleReady  (sample_ready),
    .mute         (mute),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Transaction model and serial decoder, sampled on the falling clk edge.
  bit          mon_rst_pend = 1'b1;
  bit          pend_acc = 1'b0;
  bit          pend_mute = 1'b0;
  logic [31:0] pend_word = 32'h0;
  bit          hold_v = 1'b0;
  logic [31:0] hold_w = 32'h0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  bit          prev_bclk = 1'b0;
  bit          prev_lr = 1'b1;
  bit          lr_fell = 1'b0;
  bit          have_frame = 1'b0;
  bit          mon_frame_start;
  logic [31:0] acc_bits = 32'h0;
  int          nbits = 0;
  int          accepts_since = 0;
  int          frames_checked = 0;
  int          nonzero_frames = 0;

  always @(negedge clk) begin
    if (mon_rst_pend) begin
      checkOutput("rst_bclk", 32'(bclk), 32'd0);
      checkOutput("rst_lrclk", 32'(lrclk), 32'd1);
      checkOutput("rst_sdata", 32'(sdata), 32'd0);
      checkOutput("rst_underrun", 32'(underrun), 32'd0);
      checkOutput("rst_ready", 32'(sample_ready), 32'd1);
      hold_v = 1'b0;
      exp_q.delete();
      have_frame = 1'b0;
      lr_fell = 1'b0;
      accepts_since = 0;
      prev_bclk = 1'b0;
      prev_lr = 1'b1;
    end else begin
      mon_frame_start = prev_lr && !lrclk;
      checkOutput("underrun", 32'(underrun), 32'(mon_frame_start && !hold_v));
      if (mon_frame_start) begin
        exp_q.push_back((hold_v && !pend_mute) ? hold_w : 32'h0);
        hold_v = 1'b0;
        lr_fell = 1'b1;
        checkOutput("accepts_per_frame", 32'(accepts_since > 1), 32'd0);
        accepts_since = 0;
      end
      if (pend_acc) begin
        hold_v = 1'b1;
        hold_w = pend_word;
        accepts_since++;
      end
      checkOutput("sampleReady", 32'(sample_ready), 32'(!hold_v));
      if (bclk && !prev_bclk) begin
        if (lr_fell) begin
          if (have_frame) begin
            checkOutput("slot_count", 32'(nbits), 32'd31);
            if (exp_q.size() == 0) begin
              tests_run++;
              tests_failed++;
              $display("[TB] FAIL frame_unexpected: got frame 0x%0h, expected no frame", {acc_bits[30:0], sdata});
            end else begin
              exp_word = exp_q.pop_front();
              checkOutput("frame_data", {acc_bits[30:0], sdata}, exp_word);
              frames_checked++;
              if (exp_word != 32'h0) nonzero_frames++;
            end
          end
          have_frame = 1'b1;
          nbits = 0;
          acc_bits = 32'h0;
          lr_fell = 1'b0;
        end else if (have_frame) begin
          acc_bits = {acc_bits[30:0], sdata};
          nbits++;
        end
      end
      prev_bclk = bclk;
      prev_lr = lrclk;
    end
    mon_rst_pend = reset;
    pend_acc = valid && sample_ready && !reset;
    pend_mute = mute;
    pend_word = {left_in, right_in};
  end

  typedef struct {
    int   n;
    logic mute_in;
    logic exp_bclk;
    logic exp_lrclk;
    logic exp_sdata;
    logic exp_underrun;
    logic exp_ready;
  } vec_t;

  vec_t vecs[14];

  task automatic waitCyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 4000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_cycle: got cycle %0d, expected %0d", cyc, n);
    end
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input bit keep);
    bit rdy;
    int waited = 0;
    left_in = l;
    right_in = r;
    valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = sample_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 2000) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL accept_timeout: got no accept in %0d cycles, expected accept", waited);
        break;
      end
    end
    if (!keep) valid = 1'b0;
  endtask

  task automatic waitReady();
    int waited = 0;
    while (!sample_ready && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("ready_return", 32'(sample_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{7,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{9,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{12,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{135, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{136, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{263, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{264, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{265, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{520, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    doReset(2);

    // Idle timing; the mute pulse across frame start 264 must not hide the underrun.
    for (int i = 0; i < 14; i++) begin
      waitCyc(vecs[i].n);
      checkOutput($sformatf("idle_bclk_n%0d", vecs[i].n), 32'(bclk), 32'(vecs[i].exp_bclk));
      checkOutput($sformatf("idle_lrclk_n%0d", vecs[i].n), 32'(lrclk), 32'(vecs[i].exp_lrclk));
      checkOutput($sformatf("idle_sdata_n%0d", vecs[i].n), 32'(sdata), 32'(vecs[i].exp_sdata));
      checkOutput($sformatf("idle_underrun_n%0d", vecs[i].n), 32'(underrun), 32'(vecs[i].exp_underrun));
      checkOutput($sformatf("idle_ready_n%0d", vecs[i].n), 32'(sample_ready), 32'(vecs[i].exp_ready));
      mute = vecs[i].mute_in;
    end

    applyStimulus(16'h8001, 16'h7FFE, 1'b0);
    repeat (3 * FRAME) @(posedge clk);
    #1;
    checkOutput("single_pair_frames", 32'(nonzero_frames), 32'd1);

    for (int n = 1; n <= 8; n++) begin
      applyStimulus(16'(n), 16'(-n), n < 8);
    end
    repeat (3 * FRAME) @(posedge clk);
    #1;
    checkOutput("b2b_frames", 32'(nonzero_frames), 32'd9);

    // Accept landing exactly on an empty frame start.
    doReset(1);
    waitCyc(263);
    left_in = 16'hAAAA;
    right_in = 16'h5555;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    checkOutput("fs_accept_underrun", 32'(underrun), 32'd1);
    checkOutput("fs_accept_ready", 32'(sample_ready), 32'd0);
    checkOutput("fs_accept_lrclk", 32'(lrclk), 32'd0);
    repeat (3 * FRAME) @(posedge clk);
    #1;
    checkOutput("fs_accept_frames", 32'(nonzero_frames), 32'd10);

    mute = 1'b1;
    applyStimulus(16'h1234, 16'h5678, 1'b1);
    applyStimulus(16'h1234, 16'h5678, 1'b1);
    applyStimulus(16'h1234, 16'h5678, 1'b0);
    waitReady();
    @(posedge clk);
    #1;
    mute = 1'b0;
    repeat (2 * FRAME) @(posedge clk);
    #1;
    checkOutput("mute_frames", 32'(nonzero_frames), 32'd10);

    // Reset in the middle of a frame while a pair is held.
    doReset(1);
    waitCyc(20);
    applyStimulus(16'hCAFE, 16'hBEEF, 1'b0);
    waitCyc(90);
    checkOutput("midrst_held_ready", 32'(sample_ready), 32'd0);
    doReset(1);
    checkOutput("midrst_bclk", 32'(bclk), 32'd0);
    checkOutput("midrst_lrclk", 32'(lrclk), 32'd1);
    checkOutput("midrst_sdata", 32'(sdata), 32'd0);
    checkOutput("midrst_ready", 32'(sample_ready), 32'd1);
    waitCyc(7);
    checkOutput("midrst_lrclk_n7", 32'(lrclk), 32'd1);
    waitCyc(8);
    checkOutput("midrst_lrclk_n8", 32'(lrclk), 32'd0);
    checkOutput("midrst_underrun_n8", 32'(underrun), 32'd1);
    repeat (2 * FRAME) @(posedge clk);
    #1;
    checkOutput("midrst_frames", 32'(nonzero_frames), 32'd10);
    checkOutput("frames_seen", 32'(frames_checked >= 15), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
